// File: rtl/balance_store_pkg.sv
// rtl/balance_store_pkg.sv - shared toll constants and top-up FSM encoding
package balance_store_pkg;

    localparam int ID_W  = 4;
    localparam int BAL_W = 8;

    localparam logic [BAL_W-1:0] TOLL_AMOUNT = 8'd50;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_APPLY = 2'd1,
        T_DONE  = 2'd2
    } topup_state_e;

endpackage

// File: rtl/balance_store_topup_engine.sv
// rtl/balance_store_topup_engine.sv - recharge handshake FSM with saturating read-modify-write
module balance_store_topup_engine
    import balance_store_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [ID_W-1:0]  i_id,
    input  logic [BAL_W-1:0] i_amount,
    output logic             o_done,
    output logic             o_saturated,
    input  logic             i_ctrl_we,
    input  logic [ID_W-1:0]  i_ctrl_addr,
    output logic [ID_W-1:0]  o_rd_addr,
    input  logic [BAL_W-1:0] i_rd_data,
    output logic             o_wr_en,
    output logic [ID_W-1:0]  o_wr_addr,
    output logic [BAL_W-1:0] o_wr_data
);

    topup_state_e     r_state;
    logic             r_ready;
    logic             r_done;
    logic             r_saturated;
    logic [ID_W-1:0]  r_id;
    logic [BAL_W-1:0] r_amount;

    logic [BAL_W:0]   w_sum;
    logic             w_conflict;

    // The controller owns the port: a write to our ID this cycle defers the commit.
    assign w_conflict = i_ctrl_we && (i_ctrl_addr == r_id);
    assign w_sum      = {1'b0, i_rd_data} + {1'b0, r_amount};

    assign o_rd_addr  = r_id;
    assign o_wr_addr  = r_id;
    assign o_wr_en    = (r_state == T_APPLY) && !w_conflict;
    assign o_wr_data  = w_sum[BAL_W] ? {BAL_W{1'b1}} : w_sum[BAL_W-1:0];

    assign o_ready     = r_ready;
    assign o_done      = r_done;
    assign o_saturated = r_saturated;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= T_IDLE;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_saturated <= 1'b0;
            r_id        <= '0;
            r_amount    <= '0;
        end else begin
            r_done      <= 1'b0;
            r_saturated <= 1'b0;
            case (r_state)
                T_IDLE: begin
                    if (i_valid && r_ready) begin
                        r_id     <= i_id;
                        r_amount <= i_amount;
                        r_ready  <= 1'b0;
                        r_state  <= T_APPLY;
                    end
                end
                T_APPLY: begin
                    if (!w_conflict) begin
                        r_done      <= 1'b1;
                        r_saturated <= w_sum[BAL_W];
                        r_state     <= T_DONE;
                    end
                end
                T_DONE: begin
                    r_ready <= 1'b1;
                    r_state <= T_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= T_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/balance_store.sv
// rtl/balance_store.sv - 16x8 balance array with controller port, write-first read and top-up port
module balance_store
    import balance_store_pkg::ID_W, balance_store_pkg::BAL_W;
#(
    parameter logic [BAL_W-1:0] INIT_BALANCE = 8'd100,
    parameter logic [BAL_W-1:0] TOLL_AMOUNT  = balance_store_pkg::TOLL_AMOUNT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ID_W-1:0]  mem_addr,
    input  logic             mem_write_enable,
    input  logic [BAL_W-1:0] data_to_mem,
    output logic [BAL_W-1:0] balance_from_mem,
    output logic             low_balance,
    input  logic             topup_valid,
    output logic             topup_ready,
    input  logic [ID_W-1:0]  topup_id,
    input  logic [BAL_W-1:0] topup_amount,
    output logic             topup_done,
    output logic             topup_saturated,
    output logic [15:0]      toll_count
);

    localparam int DEPTH = 1 << ID_W;

    logic [BAL_W-1:0] r_mem [DEPTH];
    logic [BAL_W-1:0] r_balance;
    logic             r_low;
    logic [15:0]      r_toll_count;

    logic [ID_W-1:0]  w_tu_rd_addr;
    logic             w_tu_wr_en;
    logic [ID_W-1:0]  w_tu_wr_addr;
    logic [BAL_W-1:0] w_tu_wr_data;
    logic [BAL_W-1:0] w_rd_data;

    balance_store_topup_engine u_topup (
        .clk         (clk),
        .rst_n       (reset),
        .i_valid     (topup_valid),
        .o_ready     (topup_ready),
        .i_id        (topup_id),
        .i_amount    (topup_amount),
        .o_done      (topup_done),
        .o_saturated (topup_saturated),
        .i_ctrl_we   (mem_write_enable),
        .i_ctrl_addr (mem_addr),
        .o_rd_addr   (w_tu_rd_addr),
        .i_rd_data   (r_mem[w_tu_rd_addr]),
        .o_wr_en     (w_tu_wr_en),
        .o_wr_addr   (w_tu_wr_addr),
        .o_wr_data   (w_tu_wr_data)
    );

    // Write-first: either port's same-cycle write to the read address is forwarded.
    always_comb begin
        w_rd_data = r_mem[mem_addr];
        if (mem_write_enable) begin
            w_rd_data = data_to_mem;
        end else if (w_tu_wr_en && (w_tu_wr_addr == mem_addr)) begin
            w_rd_data = w_tu_wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= INIT_BALANCE;
            end
        end else begin
            if (mem_write_enable) begin
                r_mem[mem_addr] <= data_to_mem;
            end
            if (w_tu_wr_en) begin
                r_mem[w_tu_wr_addr] <= w_tu_wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_balance    <= INIT_BALANCE;
            r_low        <= (INIT_BALANCE < TOLL_AMOUNT);
            r_toll_count <= '0;
        end else begin
            r_balance <= w_rd_data;
            r_low     <= (w_rd_data < TOLL_AMOUNT);
            if (mem_write_enable && (r_toll_count != 16'hFFFF)) begin
                r_toll_count <= r_toll_count + 16'd1;
            end
        end
    end

    assign balance_from_mem = r_balance;
    assign low_balance      = r_low;
    assign toll_count       = r_toll_count;

endmodule
